// File: rtl/scan_seq_pkg.sv
// Shared types and defaults for the scan chain sequencer.
package scan_seq_pkg;

  localparam int unsigned CHAIN_LEN_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    CAPTURE = 2'd2,
    FLUSH   = 2'd3
  } state_e;

endpackage

// File: rtl/scan_resp_compare.sv
// Unload capture and compare of scan responses against the pending expected vector.
// Optional X-masking of compared bits when SCAN_SEQ_XMASK_EN is defined.
module scan_resp_compare
  import scan_seq_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 shift_i,
  input  logic                 so0_i,
  input  logic                 so1_i,
  input  logic                 load_i,
  input  logic [CHAIN_LEN-1:0] exp0_i,
  input  logic [CHAIN_LEN-1:0] exp1_i,
`ifdef SCAN_SEQ_XMASK_EN
  input  logic [CHAIN_LEN-1:0] mask0_i,
  input  logic [CHAIN_LEN-1:0] mask1_i,
`endif
  input  logic                 cmp_i,
  input  logic                 clr_i,
  output logic                 pend_o,
  output logic                 res_valid_o,
  output logic                 res_fail_o,
  output logic [CHAIN_LEN-1:0] map0_o,
  output logic [CHAIN_LEN-1:0] map1_o
);

  logic [CHAIN_LEN-1:0] rx0_q, rx0_d, rx1_q, rx1_d;
  logic [CHAIN_LEN-1:0] pexp0_q, pexp0_d, pexp1_q, pexp1_d;
  logic [CHAIN_LEN-1:0] care0_c, care1_c, fmap0_c, fmap1_c;
  logic [CHAIN_LEN-1:0] map0_q, map0_d, map1_q, map1_d;
  logic                 pend_q, pend_d, valid_q, valid_d, fail_q, fail_d;
`ifdef SCAN_SEQ_XMASK_EN
  logic [CHAIN_LEN-1:0] pmask0_q, pmask0_d, pmask1_q, pmask1_d;
`endif

  // Compare uses the rx value including the bit sampled on this final shift.
  always_comb begin
    rx0_d   = rx0_q;
    rx1_d   = rx1_q;
    pexp0_d = pexp0_q;
    pexp1_d = pexp1_q;
    pend_d  = pend_q;
    if (shift_i) begin
      rx0_d = {rx0_q[CHAIN_LEN-2:0], so0_i};
      rx1_d = {rx1_q[CHAIN_LEN-2:0], so1_i};
    end
`ifdef SCAN_SEQ_XMASK_EN
    pmask0_d = pmask0_q;
    pmask1_d = pmask1_q;
    care0_c  = ~pmask0_q;
    care1_c  = ~pmask1_q;
    if (load_i) begin
      pmask0_d = mask0_i;
      pmask1_d = mask1_i;
    end
`else
    care0_c  = {CHAIN_LEN{1'b1}};
    care1_c  = {CHAIN_LEN{1'b1}};
`endif
    fmap0_c = (rx0_d ^ pexp0_q) & care0_c;
    fmap1_c = (rx1_d ^ pexp1_q) & care1_c;
    if (load_i) begin
      pexp0_d = exp0_i;
      pexp1_d = exp1_i;
      pend_d  = 1'b1;
    end else if (clr_i) begin
      pend_d  = 1'b0;
    end
    valid_d = cmp_i & pend_q;
    map0_d  = valid_d ? fmap0_c : map0_q;
    map1_d  = valid_d ? fmap1_c : map1_q;
    fail_d  = valid_d ? (|{fmap0_c, fmap1_c}) : fail_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      rx0_q    <= '0;
      rx1_q    <= '0;
      pexp0_q  <= '0;
      pexp1_q  <= '0;
      pend_q   <= 1'b0;
      valid_q  <= 1'b0;
      fail_q   <= 1'b0;
      map0_q   <= '0;
      map1_q   <= '0;
`ifdef SCAN_SEQ_XMASK_EN
      pmask0_q <= '0;
      pmask1_q <= '0;
`endif
    end else begin
      rx0_q    <= rx0_d;
      rx1_q    <= rx1_d;
      pexp0_q  <= pexp0_d;
      pexp1_q  <= pexp1_d;
      pend_q   <= pend_d;
      valid_q  <= valid_d;
      fail_q   <= fail_d;
      map0_q   <= map0_d;
      map1_q   <= map1_d;
`ifdef SCAN_SEQ_XMASK_EN
      pmask0_q <= pmask0_d;
      pmask1_q <= pmask1_d;
`endif
    end
  end

  assign pend_o      = pend_q;
  assign res_valid_o = valid_q;
  assign res_fail_o  = fail_q;
  assign map0_o      = map0_q;
  assign map1_o      = map1_q;

endmodule

// File: rtl/scan_chain_sequencer.sv
// Load/capture/unload sequencer for a two-chain scan datapath with per-pattern compare.
// Define SCAN_SEQ_XMASK_EN to add pat_mask0/pat_mask1 X-mask inputs.
module scan_chain_sequencer
  import scan_seq_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 pat_valid,
  output logic                 pat_ready,
  input  logic                 pat_last,
  input  logic [CHAIN_LEN-1:0] pat_si0,
  input  logic [CHAIN_LEN-1:0] pat_si1,
  input  logic [CHAIN_LEN-1:0] pat_exp0,
  input  logic [CHAIN_LEN-1:0] pat_exp1,
`ifdef SCAN_SEQ_XMASK_EN
  input  logic [CHAIN_LEN-1:0] pat_mask0,
  input  logic [CHAIN_LEN-1:0] pat_mask1,
`endif
  output logic                 SE,
  output logic                 SI0,
  output logic                 SI1,
  input  logic                 SO0,
  input  logic                 SO1,
  output logic                 capture_pulse,
  output logic                 res_valid,
  output logic                 res_fail,
  output logic [CHAIN_LEN-1:0] res_fail_map0,
  output logic [CHAIN_LEN-1:0] res_fail_map1,
  output logic                 done
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] sh0_q, sh0_d, sh1_q, sh1_d;
  logic [CHAIN_LEN-1:0] exp0_q, exp0_d, exp1_q, exp1_d;
  logic                 last_q, last_d, done_q, done_d;
  logic                 se_q, se_d, cap_q, cap_d, rdy_q, rdy_d;
  logic                 hs_c, shift_c, load_c, cmp_c, clr_c, pend_c;
`ifdef SCAN_SEQ_XMASK_EN
  logic [CHAIN_LEN-1:0] mask0_q, mask0_d, mask1_q, mask1_d;
`endif

  assign hs_c = pat_valid & rdy_q;

  // Next state; shift registers drain to zero, so FLUSH shifts zeros in naturally.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh0_d   = sh0_q;
    sh1_d   = sh1_q;
    exp0_d  = exp0_q;
    exp1_d  = exp1_q;
    last_d  = last_q;
    done_d  = done_q;
    shift_c = 1'b0;
    load_c  = 1'b0;
    cmp_c   = 1'b0;
    clr_c   = 1'b0;
`ifdef SCAN_SEQ_XMASK_EN
    mask0_d = mask0_q;
    mask1_d = mask1_q;
`endif
    case (state_q)
      IDLE: begin
        if (hs_c) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sh0_d   = pat_si0;
          sh1_d   = pat_si1;
          exp0_d  = pat_exp0;
          exp1_d  = pat_exp1;
          last_d  = pat_last;
          done_d  = 1'b0;
`ifdef SCAN_SEQ_XMASK_EN
          mask0_d = pat_mask0;
          mask1_d = pat_mask1;
`endif
        end else if (last_q && pend_c) begin
          state_d = FLUSH;
          cnt_d   = '0;
          sh0_d   = '0;
          sh1_d   = '0;
        end
      end
      SHIFT, FLUSH: begin
        shift_c = 1'b1;
        sh0_d   = {sh0_q[CHAIN_LEN-2:0], 1'b0};
        sh1_d   = {sh1_q[CHAIN_LEN-2:0], 1'b0};
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
          cmp_c = 1'b1;
          cnt_d = '0;
          if (state_q == SHIFT) begin
            state_d = CAPTURE;
          end else begin
            state_d = IDLE;
            clr_c   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      CAPTURE: begin
        load_c  = 1'b1;
        cnt_d   = '0;
        state_d = last_q ? FLUSH : IDLE;
      end
      default: state_d = IDLE;
    endcase
    se_d  = (state_d == SHIFT) || (state_d == FLUSH);
    cap_d = (state_d == CAPTURE);
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh0_q   <= '0;
      sh1_q   <= '0;
      exp0_q  <= '0;
      exp1_q  <= '0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      se_q    <= 1'b0;
      cap_q   <= 1'b0;
      rdy_q   <= 1'b0;
`ifdef SCAN_SEQ_XMASK_EN
      mask0_q <= '0;
      mask1_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh0_q   <= sh0_d;
      sh1_q   <= sh1_d;
      exp0_q  <= exp0_d;
      exp1_q  <= exp1_d;
      last_q  <= last_d;
      done_q  <= done_d;
      se_q    <= se_d;
      cap_q   <= cap_d;
      rdy_q   <= rdy_d;
`ifdef SCAN_SEQ_XMASK_EN
      mask0_q <= mask0_d;
      mask1_q <= mask1_d;
`endif
    end
  end

  scan_resp_compare #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_cmp (
    .CLK         (CLK),
    .RSTN        (RSTN),
    .shift_i     (shift_c),
    .so0_i       (SO0),
    .so1_i       (SO1),
    .load_i      (load_c),
    .exp0_i      (exp0_q),
    .exp1_i      (exp1_q),
`ifdef SCAN_SEQ_XMASK_EN
    .mask0_i     (mask0_q),
    .mask1_i     (mask1_q),
`endif
    .cmp_i       (cmp_c),
    .clr_i       (clr_c),
    .pend_o      (pend_c),
    .res_valid_o (res_valid),
    .res_fail_o  (res_fail),
    .map0_o      (res_fail_map0),
    .map1_o      (res_fail_map1)
  );

  assign pat_ready     = rdy_q;
  assign SE            = se_q;
  assign SI0           = sh0_q[CHAIN_LEN-1];
  assign SI1           = sh1_q[CHAIN_LEN-1];
  assign capture_pulse = cap_q;
  assign done          = done_q;

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Scoreboard bench: loopback scan chain model, expected results queued per accepted pattern.
module tb_scan_chain_sequencer;
  import scan_seq_pkg::*;

  localparam int unsigned L = 8;

  typedef struct packed {
    logic         fail;
    logic [L-1:0] m0;
    logic [L-1:0] m1;
  } res_t;

  logic         CLK = 1'b0;
  logic         RSTN = 1'b0;
  logic         pat_valid, pat_ready, pat_last;
  logic [L-1:0] pat_si0, pat_si1, pat_exp0, pat_exp1, pat_mask0, pat_mask1;
  logic         SE, SI0, SI1, SO0, SO1, capture_pulse;
  logic         res_valid, res_fail, done;
  logic [L-1:0] res_fail_map0, res_fail_map1;

  logic [L-1:0] chain0 = '0;
  logic [L-1:0] chain1 = '0;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   se_cnt = 0, cap_cnt = 0, rv_cnt = 0, se_run = 0, runs_bad = 0;

  always #5 CLK = ~CLK;

  scan_chain_sequencer #(.CHAIN_LEN(L)) dut (
    .CLK           (CLK),
    .RSTN          (RSTN),
    .pat_valid     (pat_valid),
    .pat_ready     (pat_ready),
    .pat_last      (pat_last),
    .pat_si0       (pat_si0),
    .pat_si1       (pat_si1),
    .pat_exp0      (pat_exp0),
    .pat_exp1      (pat_exp1),
`ifdef SCAN_SEQ_XMASK_EN
    .pat_mask0     (pat_mask0),
    .pat_mask1     (pat_mask1),
`endif
    .SE            (SE),
    .SI0           (SI0),
    .SI1           (SI1),
    .SO0           (SO0),
    .SO1           (SO1),
    .capture_pulse (capture_pulse),
    .res_valid     (res_valid),
    .res_fail      (res_fail),
    .res_fail_map0 (res_fail_map0),
    .res_fail_map1 (res_fail_map1),
    .done          (done)
  );

  // Scan chains with no functional capture path: capture leaves contents unchanged.
  always @(posedge CLK) begin
    if (SE) begin
      chain0 <= {chain0[L-2:0], SI0};
      chain1 <= {chain1[L-2:0], SI1};
    end
  end
  assign SO0 = chain0[L-1];
  assign SO1 = chain1[L-1];

  // Monitor: pops the scoreboard on every result and tracks SE/capture activity.
  always @(negedge CLK) begin
    res_t r;
    if (SE) begin
      se_cnt++;
      se_run++;
    end else begin
      if (se_run != 0 && se_run != L) runs_bad++;
      se_run = 0;
    end
    if (capture_pulse) cap_cnt++;
    if (res_valid) begin
      rv_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL res_unexpected: got fail=%0b map0=%h map1=%h with no pattern outstanding",
                 res_fail, res_fail_map0, res_fail_map1);
      end else begin
        r = exp_q.pop_front();
        if ({res_fail, res_fail_map0, res_fail_map1} !== r) begin
          errors++;
          $display("FAIL res_compare: got fail=%0b map0=%h map1=%h, want fail=%0b map0=%h map1=%h",
                   res_fail, res_fail_map0, res_fail_map1, r.fail, r.m0, r.m1);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic res_t model(input logic [L-1:0] si0, si1, e0, e1, m0, m1);
    res_t r;
    logic [L-1:0] c0, c1;
`ifdef SCAN_SEQ_XMASK_EN
    c0 = ~m0;
    c1 = ~m1;
`else
    c0 = {L{1'b1}} ^ (m0 & 8'h00);
    c1 = {L{1'b1}} ^ (m1 & 8'h00);
`endif
    r.m0   = (si0 ^ e0) & c0;
    r.m1   = (si1 ^ e1) & c1;
    r.fail = |{r.m0, r.m1};
    return r;
  endfunction

  // Offer one pattern; returns at the negedge just after the handshake edge.
  task automatic send(input logic [L-1:0] si0, si1, e0, e1, m0, m1, input logic last);
    int n;
    @(negedge CLK);
    pat_si0 = si0; pat_si1 = si1; pat_exp0 = e0; pat_exp1 = e1;
    pat_mask0 = m0; pat_mask1 = m1; pat_last = last; pat_valid = 1'b1;
    n = 0;
    while (!pat_ready && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!pat_ready) chk("send_timeout", 32'(pat_ready), 32'd1);
    exp_q.push_back(model(si0, si1, e0, e1, m0, m1));
    @(negedge CLK);
    pat_valid = 1'b0;
    pat_last  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk("done_seen", 32'(done), 32'd1);
    @(negedge CLK);
    #1;
  endtask

  initial begin
    int b_se, b_cap, b_rv, b_bad;
    res_t mm;
    pat_valid = 1'b0; pat_last = 1'b0;
    pat_si0 = '0; pat_si1 = '0; pat_exp0 = '0; pat_exp1 = '0;
    pat_mask0 = '0; pat_mask1 = '0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_se", 32'(SE), 32'd0);
    chk("rst_ready", 32'(pat_ready), 32'd0);
    chk("rst_cap", 32'(capture_pulse), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    RSTN = 1'b1;
    repeat (4) @(negedge CLK);
    #1;
    chk("idle_se", 32'(SE), 32'd0);
    chk("idle_ready", 32'(pat_ready), 32'd1);
    chk("idle_no_res", 32'(rv_cnt), 32'd0);

    // Two-pattern loopback with an idle gap between them
    send(8'hA5, 8'h3C, 8'hA5, 8'h3C, 8'h00, 8'h00, 1'b0);
    repeat (14) @(negedge CLK);
    #1;
    chk("gap_no_res", 32'(rv_cnt), 32'd0);
    chk("gap_ready", 32'(pat_ready), 32'd1);
    send(8'h0F, 8'hF0, 8'h0F, 8'hF0, 8'h00, 8'h00, 1'b1);
    wait_done();
    chk("loop_results", 32'(rv_cnt), 32'd2);
    chk("loop_queue_empty", 32'(exp_q.size()), 32'd0);

    // Mismatch on bit 0 of chain 0 (masked out when X-masking is built in)
    send(8'hA5, 8'h3C, 8'hA4, 8'h3C, 8'h01, 8'h00, 1'b1);
    chk("done_cleared", 32'(done), 32'd0);
    wait_done();
    mm = model(8'hA5, 8'h3C, 8'hA4, 8'h3C, 8'h01, 8'h00);
    chk("mm_map0_held", 32'(res_fail_map0), 32'(mm.m0));
    chk("mm_map1_held", 32'(res_fail_map1), 32'd0);
    chk("mm_fail_held", 32'(res_fail), 32'(mm.fail));

    // Single-pattern timing: 8 shifts, capture, 8 flush shifts, one result
    b_se = se_cnt; b_cap = cap_cnt; b_rv = rv_cnt; b_bad = runs_bad;
    send(8'h5A, 8'hC3, 8'h5A, 8'hC3, 8'h00, 8'h00, 1'b1);
    wait_done();
    repeat (2) @(negedge CLK);
    #1;
    chk("tim_se_cycles", 32'(se_cnt - b_se), 32'd16);
    chk("tim_capture", 32'(cap_cnt - b_cap), 32'd1);
    chk("tim_results", 32'(rv_cnt - b_rv), 32'd1);
    chk("tim_se_runs", 32'(runs_bad - b_bad), 32'd0);

    // Reset at k=3 of a shift that would have unloaded a pending result
    send(8'h11, 8'h22, 8'h11, 8'h22, 8'h00, 8'h00, 1'b0);
    send(8'h33, 8'h44, 8'h33, 8'h44, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge CLK);
    b_rv = rv_cnt;
    RSTN = 1'b0;
    #1;
    chk("mid_rst_se", 32'(SE), 32'd0);
    exp_q.delete();
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    repeat (3) @(negedge CLK);
    #1;
    chk("post_rst_ready", 32'(pat_ready), 32'd1);
    chk("post_rst_se", 32'(SE), 32'd0);
    chk("post_rst_no_res", 32'(rv_cnt - b_rv), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);

    // Recovery: a fresh single pattern produces exactly one result
    b_rv = rv_cnt;
    send(8'h66, 8'h99, 8'h66, 8'h99, 8'h00, 8'h00, 1'b1);
    wait_done();
    chk("recov_results", 32'(rv_cnt - b_rv), 32'd1);
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
